ex_mem_buffer: RTL and testbench

- Elastic EX/MEM boundary directly downstream of the ALU.
- Captures the ALU result, the zero flag and the execute-stage control/payload into a 2-entry skid buffer with valid/ready handshakes on both sides.
- Resolves the branch decision at capture and presents the results to the memory stage.
- Decouples ALU timing from memory-stage stalls without a combinational ready path from output back to input.

---
 rtl/ex_mem_buffer.sv | 135 +++++++++++++
 tb/tb_ex_mem_buffer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_buffer.sv
// EX/MEM elastic boundary: 2-entry skid buffer that holds the ALU result and
// execute-stage payload and resolves branchTaken when an entry is captured.
// Optional stall-cycle counter port is enabled with `define EX_MEM_STALL_CNT_EN.
module ex_mem_buffer #(
  parameter int WIDTH = 32,
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] datoAlu,
  input  logic             zf,
  input  logic [WIDTH-1:0] datoRt,
  input  logic [WIDTH-1:0] pcBranch,
  input  logic [REG_W-1:0] regDest,
  input  logic [4:0]       ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_datoAlu,
  output logic             out_zf,
  output logic [WIDTH-1:0] out_datoRt,
  output logic [WIDTH-1:0] out_pcBranch,
  output logic [REG_W-1:0] out_regDest,
  output logic [4:0]       out_ctrl,
  output logic             out_branchTaken
`ifdef EX_MEM_STALL_CNT_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; valid never waits on ready, and in_ready is a function of
  // registered occupancy only, so no combinational path runs out_ready->in_ready.

  logic [1:0]       count_q, count_d;
  logic             head_q, head_d;
  logic [WIDTH-1:0] alu_q [2];
  logic             zf_q  [2];
  logic [WIDTH-1:0] rt_q  [2];
  logic [WIDTH-1:0] pc_q  [2];
  logic [REG_W-1:0] rd_q  [2];
  logic [4:0]       ctrl_q[2];
  logic             bt_q  [2];

  logic push;
  logic pop;
  logic wr_idx;
  logic wr_en;

  assign in_ready  = !rst && (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign wr_idx    = head_q ^ count_q[0];
  assign wr_en     = push && !flush;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    if (flush) begin
      count_d = 2'd0;
      head_d  = 1'b0;
    end else begin
      unique case ({push, pop})
        2'b10: count_d = count_q + 2'd1;
        2'b01: begin
          count_d = count_q - 2'd1;
          head_d  = ~head_q;
        end
        2'b11: head_d = ~head_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
      head_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        alu_q[i]  <= '0;
        zf_q[i]   <= 1'b0;
        rt_q[i]   <= '0;
        pc_q[i]   <= '0;
        rd_q[i]   <= '0;
        ctrl_q[i] <= '0;
        bt_q[i]   <= 1'b0;
      end
    end else if (wr_en) begin
      alu_q[wr_idx]  <= datoAlu;
      zf_q[wr_idx]   <= zf;
      rt_q[wr_idx]   <= datoRt;
      pc_q[wr_idx]   <= pcBranch;
      rd_q[wr_idx]   <= regDest;
      ctrl_q[wr_idx] <= ctrl;
      // Branch resolved once at capture so the MEM stage sees a plain bit.
      bt_q[wr_idx]   <= ctrl[4] & zf;
    end
  end

  assign out_datoAlu     = out_valid ? alu_q[head_q]  : '0;
  assign out_zf          = out_valid ? zf_q[head_q]   : 1'b0;
  assign out_datoRt      = out_valid ? rt_q[head_q]   : '0;
  assign out_pcBranch    = out_valid ? pc_q[head_q]   : '0;
  assign out_regDest     = out_valid ? rd_q[head_q]   : '0;
  assign out_ctrl        = out_valid ? ctrl_q[head_q] : '0;
  assign out_branchTaken = out_valid ? bt_q[head_q]   : 1'b0;

`ifdef EX_MEM_STALL_CNT_EN
  logic [31:0] stall_q;

  // Saturating; flush deliberately leaves it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (in_valid && !in_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_ex_mem_buffer.sv
// Scoreboard bench for ex_mem_buffer: directed cases followed by random
// traffic, checked every cycle against a queue-based reference model.
module tb_ex_mem_buffer;
  localparam int W  = 32;
  localparam int R  = 5;
  localparam int EW = 3 * W + R + 5 + 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] datoAlu = '0;
  logic         zf = 1'b0;
  logic [W-1:0] datoRt = '0;
  logic [W-1:0] pcBranch = '0;
  logic [R-1:0] regDest = '0;
  logic [4:0]   ctrl = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_datoAlu;
  logic         out_zf;
  logic [W-1:0] out_datoRt;
  logic [W-1:0] out_pcBranch;
  logic [R-1:0] out_regDest;
  logic [4:0]   out_ctrl;
  logic         out_branchTaken;
`ifdef EX_MEM_STALL_CNT_EN
  logic [31:0]  stall_cnt;
`endif

  ex_mem_buffer #(.WIDTH(W), .REG_W(R)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .datoAlu(datoAlu), .zf(zf), .datoRt(datoRt), .pcBranch(pcBranch),
    .regDest(regDest), .ctrl(ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_datoAlu(out_datoAlu), .out_zf(out_zf), .out_datoRt(out_datoRt),
    .out_pcBranch(out_pcBranch), .out_regDest(out_regDest),
    .out_ctrl(out_ctrl), .out_branchTaken(out_branchTaken)
`ifdef EX_MEM_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int            tests_run = 0;
  int            tests_failed = 0;
  logic          known = 1'b0;
  logic [31:0]   stall_m = '0;
  int            pops_seen = 0;

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected record: branch decision is simply "branch instruction and zero".
  function automatic logic [EW-1:0] make_entry(input logic [W-1:0] a, input logic z,
      input logic [W-1:0] rt, input logic [W-1:0] pc, input logic [R-1:0] rd, input logic [4:0] c);
    logic taken;
    taken = (c[4] == 1'b1) && (z == 1'b1);
    return {a, z, rt, pc, rd, c, taken};
  endfunction

  // monitor + reference model, sampled mid-cycle
  always @(negedge clk) begin : monitor
    int            sz;
    logic          exp_rdy;
    logic [EW-1:0] act;
    sz      = exp_q.size();
    exp_rdy = !rst && (sz < 2);
    act     = {out_datoAlu, out_zf, out_datoRt, out_pcBranch, out_regDest, out_ctrl, out_branchTaken};
    check("in_ready", EW'(in_ready), EW'(exp_rdy));
    if (known) begin
      check("out_valid", EW'(out_valid), EW'(sz != 0));
      if (sz != 0) begin
        check("head_alu", EW'(out_datoAlu), EW'(exp_q[0][EW-1 -: W]));
        check("head_entry", act, exp_q[0]);
      end else begin
        check("idle_payload_zero", act, '0);
      end
`ifdef EX_MEM_STALL_CNT_EN
      check("stall_cnt", EW'(stall_cnt), EW'(stall_m));
`endif
    end
    if (rst) begin
      exp_q.delete();
      known   = 1'b1;
      stall_m = '0;
    end else begin
      if (in_valid && !exp_rdy && stall_m != 32'hFFFF_FFFF) stall_m++;
      if (sz != 0 && out_ready) begin
        void'(exp_q.pop_front());
        pops_seen++;
      end
      if (flush) exp_q.delete();
      else if (in_valid && exp_rdy)
        exp_q.push_back(make_entry(datoAlu, zf, datoRt, pcBranch, regDest, ctrl));
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] a, input logic z,
      input logic [W-1:0] pc, input logic [R-1:0] rd, input logic [4:0] c);
    in_valid = v;
    datoAlu  = a;
    zf       = z;
    datoRt   = a ^ 32'hA5A5_0000;
    pcBranch = pc;
    regDest  = rd;
    ctrl     = c;
  endtask

  initial begin
    // reset held two cycles with a valid pending upstream
    drive(1'b1, 32'hDEAD_BEEF, 1'b1, 32'h1234, 5'd3, 5'b11111);
    step(2);
    rst = 1'b0;
    drive(1'b0, '0, 1'b0, '0, '0, '0);
    step(1);

    // single entry, 1-cycle latency, then empty again
    out_ready = 1'b1;
    drive(1'b1, 32'd5, 1'b0, 32'h0, 5'd8, 5'b00001);
    step(1);
    drive(1'b0, '0, 1'b0, '0, '0, '0);
    step(2);

    // fill with downstream stalled, extra push blocked, then drain in order
    out_ready = 1'b0;
    drive(1'b1, 32'd1, 1'b0, 32'h10, 5'd1, 5'b00011);
    step(1);
    drive(1'b1, 32'd2, 1'b0, 32'h20, 5'd2, 5'b00011);
    step(1);
    drive(1'b1, 32'd3, 1'b0, 32'h30, 5'd3, 5'b00011);
    step(2);
    drive(1'b0, '0, 1'b0, '0, '0, '0);
    out_ready = 1'b1;
    step(3);

    // count = 1 with simultaneous push and pop
    out_ready = 1'b0;
    drive(1'b1, 32'd7, 1'b0, 32'h0, 5'd7, 5'b00001);
    step(1);
    out_ready = 1'b1;
    drive(1'b1, 32'd9, 1'b0, 32'h0, 5'd9, 5'b00001);
    step(1);
    out_ready = 1'b0;
    drive(1'b0, '0, 1'b0, '0, '0, '0);
    step(1);
    out_ready = 1'b1;
    step(2);

    // branch resolution taken / not taken
    drive(1'b1, 32'd0, 1'b1, 32'h0040_0020, 5'd0, 5'b10000);
    step(1);
    drive(1'b1, 32'd0, 1'b0, 32'h0040_0020, 5'd0, 5'b10000);
    step(1);
    drive(1'b0, '0, 1'b0, '0, '0, '0);
    step(2);

    // full buffer, three blocked cycles, flush with a push pending
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 32'h11, 1'b0, 32'h0, 5'd1, 5'b00001);
    step(1);
    drive(1'b1, 32'h22, 1'b0, 32'h0, 5'd2, 5'b00001);
    step(1);
    drive(1'b1, 32'h33, 1'b0, 32'h0, 5'd3, 5'b00001);
    step(3);
    flush = 1'b1;
    drive(1'b1, 32'h44, 1'b0, 32'h0, 5'd4, 5'b00001);
    step(1);
    flush = 1'b0;
    drive(1'b0, '0, 1'b0, '0, '0, '0);
    out_ready = 1'b1;
    step(2);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 1)),
            $urandom, R'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      rst       = ($urandom_range(0, 150) == 0);
      step(1);
    end
    rst = 1'b0;
    flush = 1'b0;
    drive(1'b0, '0, 1'b0, '0, '0, '0);
    out_ready = 1'b1;
    step(4);

    tests_run++;
    if (pops_seen < 100) begin
      tests_failed++;
      $display("FAIL traffic_volume: got %0d pops expected at least 100", pops_seen);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
